// File: rtl/dqpsk_pkg.sv
// Shared types, constants and helpers for the DQPSK transmit path.
package dqpsk_pkg;

    typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, FLUSH} state_t;

    // Raised-cosine-like envelope, one weight per sample of a symbol.
    localparam int unsigned ENV_LEN = 5;
    localparam int unsigned ENV_WEIGHT [ENV_LEN] = '{1, 3, 5, 3, 1};

    // 1/sqrt(2) in Q8, projects the envelope onto each of I and Q.
    localparam int unsigned INV_SQRT2_Q8 = 181;

    // Gray dibit to phase increment in quarter turns.
    function automatic logic [1:0] gray_to_inc(input logic [1:0] dibit);
        logic [1:0] inc;
        case (dibit)
            2'b00:   inc = 2'd0;
            2'b01:   inc = 2'd1;
            2'b11:   inc = 2'd2;
            default: inc = 2'd3;
        endcase
        return inc;
    endfunction

    // Phase to {i_negative, q_negative}.
    function automatic logic [1:0] phase_to_sign(input logic [1:0] phase);
        logic [1:0] sgn;
        case (phase)
            2'd0:    sgn = 2'b00;
            2'd1:    sgn = 2'b10;
            2'd2:    sgn = 2'b11;
            default: sgn = 2'b01;
        endcase
        return sgn;
    endfunction

endpackage

// File: rtl/dqpsk_mapper.sv
// Registered mapping of (phase, sample index) to signed I/Q and envelope samples.
module dqpsk_mapper
    import dqpsk_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned AMP_SCALE  = 10,
    parameter int unsigned IDX_W      = 3
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         ce,
    input  logic                         strobe,
    input  logic                         zero,
    input  logic [1:0]                   phase,
    input  logic [IDX_W-1:0]             idx,
    output logic signed [DATA_WIDTH-1:0] i_sample,
    output logic signed [DATA_WIDTH-1:0] q_sample,
    output logic [DATA_WIDTH-1:0]        amp_sample,
    output logic                         strobe_out
);

    logic [DATA_WIDTH-1:0] amp;
    logic [DATA_WIDTH+7:0] prod;
    logic [DATA_WIDTH-1:0] mag;
    logic [DATA_WIDTH-1:0] neg_mag;
    logic [1:0]            sgn;
    logic                  strobe_q;

    // Envelope lookup and projection onto the I/Q axes.
    always_comb begin
        amp = '0;
        if (!zero && (32'(idx) < ENV_LEN)) begin
            amp = DATA_WIDTH'(ENV_WEIGHT[idx] * AMP_SCALE);
        end
        prod    = (DATA_WIDTH + 8)'(amp) * (DATA_WIDTH + 8)'(INV_SQRT2_Q8);
        mag     = prod[DATA_WIDTH+7:8];
        neg_mag = '0 - mag;
        sgn     = phase_to_sign(phase);
    end

    // Sample registers load only on a qualified strobe; the pulse register tracks it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_sample   <= '0;
            q_sample   <= '0;
            amp_sample <= '0;
            strobe_q   <= 1'b0;
        end else begin
            strobe_q <= strobe;
            if (strobe) begin
                i_sample   <= sgn[1] ? neg_mag : mag;
                q_sample   <= sgn[0] ? neg_mag : mag;
                amp_sample <= amp;
            end
        end
    end

    // A pending pulse is suppressed while the block is stalled.
    assign strobe_out = strobe_q & ce;

endmodule

// File: rtl/dqpsk_modulator.sv
// DQPSK symbol generator: preamble, data and flush symbols at SPS samples per symbol.
// Optional build macro DQPSK_PRBS_EN replaces the dibit handshake with an internal PRBS-7.
module dqpsk_modulator
    import dqpsk_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 16,
    parameter int unsigned SPS           = 5,
    parameter int unsigned AMP_SCALE     = 10,
    parameter int unsigned PREAMBLE_LEN  = 8,
    parameter int unsigned FRAME_SYMBOLS = 64
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         ce,
    input  logic                         strobe_in,
    input  logic                         start,
    input  logic                         sym_valid,
    input  logic [1:0]                   sym_data,
    output logic                         sym_ready,
    output logic signed [DATA_WIDTH-1:0] I_out,
    output logic signed [DATA_WIDTH-1:0] Q_out,
    output logic [DATA_WIDTH-1:0]        Amp_out,
    output logic                         strobe_out,
    output logic                         busy,
    output logic [6:0]                   sym_count,
    output logic                         underrun
);

    localparam int unsigned IDX_W = (SPS > 1) ? $clog2(SPS) : 1;
    localparam int unsigned PRE_W = (PREAMBLE_LEN > 0) ? $clog2(PREAMBLE_LEN + 1) : 1;

    state_t             state_q, state_d;
    logic [1:0]         phase_q, phase_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [PRE_W-1:0]   pre_cnt_q, pre_cnt_d;
    logic [6:0]         sym_count_q, sym_count_d;
    logic               underrun_q, underrun_d;
    logic               hold_full_q, hold_full_d;
    logic [1:0]         hold_data_q, hold_data_d;
    logic               strobe;
    logic               boundary;
    logic               data_sym;
    logic               zero;

`ifdef DQPSK_PRBS_EN
    logic [6:0] lfsr_q, lfsr_d;
    logic [6:0] lfsr_s1, lfsr_s2;
    logic       fb1, fb2;

    // Two steps of x^7+x^6+1 per data symbol; the two feedback bits form the dibit.
    always_comb begin
        fb1     = lfsr_q[6] ^ lfsr_q[5];
        lfsr_s1 = {lfsr_q[5:0], fb1};
        fb2     = lfsr_s1[6] ^ lfsr_s1[5];
        lfsr_s2 = {lfsr_s1[5:0], fb2};
    end

    assign sym_ready = 1'b0;
`else
    assign sym_ready = ~hold_full_q;
`endif

    assign strobe   = strobe_in & ce;
    assign boundary = strobe && (idx_q == '0);

    // Frame sequencing, phase accumulation and holding-register handshake.
    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        idx_d       = idx_q;
        pre_cnt_d   = pre_cnt_q;
        sym_count_d = sym_count_q;
        underrun_d  = underrun_q;
        hold_full_d = hold_full_q;
        hold_data_d = hold_data_q;
        data_sym    = 1'b0;
`ifdef DQPSK_PRBS_EN
        lfsr_d      = lfsr_q;
`endif

        if (strobe) begin
            idx_d = (idx_q == IDX_W'(SPS - 1)) ? '0 : idx_q + 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (start && ce) begin
                    state_d     = PREAMBLE;
                    phase_d     = 2'd0;
                    idx_d       = '0;
                    pre_cnt_d   = '0;
                    sym_count_d = '0;
                    underrun_d  = 1'b0;
`ifdef DQPSK_PRBS_EN
                    lfsr_d      = 7'h7F;
`endif
                end
            end
            PREAMBLE: begin
                if (boundary) begin
                    if (32'(pre_cnt_q) < PREAMBLE_LEN) begin
                        // First preamble symbol is the phase reference.
                        if (pre_cnt_q != '0) phase_d = phase_q + 2'd2;
                        pre_cnt_d = pre_cnt_q + 1'b1;
                    end else begin
                        state_d  = DATA;
                        data_sym = 1'b1;
                    end
                end
            end
            DATA: begin
                if (boundary) begin
                    if (32'(sym_count_q) < FRAME_SYMBOLS) data_sym = 1'b1;
                    else                                   state_d  = FLUSH;
                end
            end
            FLUSH: begin
                if (boundary) state_d = IDLE;
            end
        endcase

        if (data_sym) begin
            sym_count_d = sym_count_q + 7'd1;
`ifdef DQPSK_PRBS_EN
            phase_d = phase_q + gray_to_inc({fb1, fb2});
            lfsr_d  = lfsr_s2;
`else
            if (hold_full_q) begin
                phase_d     = phase_q + gray_to_inc(hold_data_q);
                hold_full_d = 1'b0;
            end else begin
                underrun_d = 1'b1;
            end
`endif
        end

        // Consume is resolved above, so a same-cycle transfer lands in the emptied register.
        if (sym_valid && sym_ready && ce) begin
            hold_full_d = 1'b1;
            hold_data_d = sym_data;
        end

        zero = (state_q == IDLE) || (state_d == FLUSH) || (state_d == IDLE);
    end

    // Control state; every update is already qualified by ce.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            phase_q     <= 2'd0;
            idx_q       <= '0;
            pre_cnt_q   <= '0;
            sym_count_q <= '0;
            underrun_q  <= 1'b0;
            hold_full_q <= 1'b0;
            hold_data_q <= 2'b00;
`ifdef DQPSK_PRBS_EN
            lfsr_q      <= 7'h7F;
`endif
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            idx_q       <= idx_d;
            pre_cnt_q   <= pre_cnt_d;
            sym_count_q <= sym_count_d;
            underrun_q  <= underrun_d;
            hold_full_q <= hold_full_d;
            hold_data_q <= hold_data_d;
`ifdef DQPSK_PRBS_EN
            lfsr_q      <= lfsr_d;
`endif
        end
    end

    assign busy      = (state_q != IDLE);
    assign sym_count = sym_count_q;
    assign underrun  = underrun_q;

    // The emitted sample uses the phase of the symbol it belongs to, i.e. the updated phase.
    dqpsk_mapper #(
        .DATA_WIDTH (DATA_WIDTH),
        .AMP_SCALE  (AMP_SCALE),
        .IDX_W      (IDX_W)
    ) u_mapper (
        .clk        (clk),
        .rst_n      (rst_n),
        .ce         (ce),
        .strobe     (strobe),
        .zero       (zero),
        .phase      (phase_d),
        .idx        (idx_q),
        .i_sample   (I_out),
        .q_sample   (Q_out),
        .amp_sample (Amp_out),
        .strobe_out (strobe_out)
    );

endmodule

// File: tb/tb_dqpsk_modulator.sv
// Directed bench for dqpsk_modulator with a sample scoreboard.
module tb_dqpsk_modulator;

    localparam int DW = 16;
    localparam int MAG [5] = '{7, 21, 35, 21, 7};
    localparam int AMP [5] = '{10, 30, 50, 30, 10};

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ce = 1'b1;
    logic          strobe_in = 1'b0;
    logic          start = 1'b0;
    logic          sym_valid = 1'b0;
    logic [1:0]    sym_data = 2'b00;
    logic          sym_ready;
    logic [DW-1:0] I_out, Q_out, Amp_out;
    logic          strobe_out, busy, underrun;
    logic [6:0]    sym_count;

    typedef struct {
        int i;
        int q;
        int a;
    } sample_t;

    sample_t exp_q[$];
    int      n_assert = 0;
    int      n_fail = 0;

    always #5 clk = ~clk;

    dqpsk_modulator #(
        .DATA_WIDTH    (DW),
        .SPS           (5),
        .AMP_SCALE     (10),
        .PREAMBLE_LEN  (2),
        .FRAME_SYMBOLS (3)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ce         (ce),
        .strobe_in  (strobe_in),
        .start      (start),
        .sym_valid  (sym_valid),
        .sym_data   (sym_data),
        .sym_ready  (sym_ready),
        .I_out      (I_out),
        .Q_out      (Q_out),
        .Amp_out    (Amp_out),
        .strobe_out (strobe_out),
        .busy       (busy),
        .sym_count  (sym_count),
        .underrun   (underrun)
    );

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic exp_sample(input int phase, input bit zero, input int k);
        sample_t s;
        s.i = 0;
        s.q = 0;
        s.a = 0;
        if (!zero) begin
            s.a = AMP[k];
            s.i = (phase == 1 || phase == 2) ? -MAG[k] : MAG[k];
            s.q = (phase >= 2) ? -MAG[k] : MAG[k];
        end
        exp_q.push_back(s);
    endtask

    // One strobe every 10 clk; called and returns at a negedge.
    task automatic strobe_once(input string tag);
        sample_t s;
        strobe_in = 1'b1;
        @(negedge clk);
        strobe_in = 1'b0;
        chk({tag, " strobe_out"}, strobe_out, 1);
        chk({tag, " scoreboard"}, (exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
            s = exp_q.pop_front();
            chk({tag, " I"}, $signed(I_out), s.i);
            chk({tag, " Q"}, $signed(Q_out), s.q);
            chk({tag, " Amp"}, Amp_out, s.a);
        end
        @(negedge clk);
        chk({tag, " pulse width"}, strobe_out, 0);
        repeat (8) @(negedge clk);
    endtask

    task automatic run_symbol(input string tag, input int phase, input bit zero);
        for (int k = 0; k < 5; k++) exp_sample(phase, zero, k);
        for (int k = 0; k < 5; k++) strobe_once(tag);
    endtask

    task automatic push_dibit(input logic [1:0] d);
        chk("ready before transfer", sym_ready, 1);
        sym_valid = 1'b1;
        sym_data  = d;
        @(negedge clk);
        sym_valid = 1'b0;
        chk("ready after transfer", sym_ready, 0);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        int seen;
        @(negedge clk);
        chk("reset I", $signed(I_out), 0);
        chk("reset Q", $signed(Q_out), 0);
        chk("reset Amp", Amp_out, 0);
        chk("reset strobe_out", strobe_out, 0);
        chk("reset busy", busy, 0);
        chk("reset sym_ready", sym_ready, 1);
        chk("reset sym_count", sym_count, 0);
        chk("reset underrun", underrun, 0);
        rst_n = 1'b1;
        @(negedge clk);

        run_symbol("idle", 0, 1'b1);

        // Frame 1: preamble of two symbols, preloaded dibit 01.
        pulse_start();
        chk("start busy", busy, 1);
        chk("start sym_count", sym_count, 0);
        push_dibit(2'b01);
        run_symbol("pre1", 0, 1'b0);
        pulse_start();
        run_symbol("pre2", 2, 1'b0);
        chk("held through preamble", sym_ready, 0);

        run_symbol("data1", 3, 1'b0);
        chk("data1 sym_count", sym_count, 1);
        chk("data1 consumed", sym_ready, 1);
        chk("data1 underrun", underrun, 0);

        run_symbol("data2 underrun", 3, 1'b0);
        chk("data2 underrun", underrun, 1);
        chk("data2 sym_count", sym_count, 2);

        // Data symbol 3 (11 -> +2) with a 50-clk ce stall after its second sample.
        push_dibit(2'b11);
        for (int k = 0; k < 5; k++) exp_sample(1, 1'b0, k);
        strobe_once("data3");
        strobe_once("data3");
        ce = 1'b0;
        seen = 0;
        for (int j = 0; j < 50; j++) begin
            strobe_in = ((j % 10) == 3);
            start     = (j == 20);
            @(negedge clk);
            if (strobe_out) seen++;
        end
        strobe_in = 1'b0;
        start     = 1'b0;
        chk("ce gap strobe_out", seen, 0);
        chk("ce gap I hold", $signed(I_out), -21);
        chk("ce gap Amp hold", Amp_out, 30);
        ce = 1'b1;
        for (int k = 2; k < 5; k++) strobe_once("data3 resume");
        chk("data3 sym_count", sym_count, 3);
        chk("data3 underrun sticky", underrun, 1);

        run_symbol("flush", 0, 1'b1);
        chk("flush busy", busy, 1);
        exp_sample(0, 1'b1, 0);
        strobe_once("idle after flush");
        chk("frame end busy", busy, 0);
        chk("frame end sym_count", sym_count, 3);
        chk("frame end underrun", underrun, 1);

        // Frame 2: start clears status, then an asynchronous reset mid-symbol.
        pulse_start();
        chk("frame2 underrun cleared", underrun, 0);
        chk("frame2 sym_count", sym_count, 0);
        push_dibit(2'b10);
        exp_sample(0, 1'b0, 0);
        strobe_once("frame2 pre1");
        #2;
        rst_n = 1'b0;
        #1;
        chk("async reset I", $signed(I_out), 0);
        chk("async reset Q", $signed(Q_out), 0);
        chk("async reset Amp", Amp_out, 0);
        chk("async reset busy", busy, 0);
        chk("async reset sym_ready", sym_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        exp_sample(0, 1'b1, 0);
        strobe_once("idle after reset");
        chk("idle after reset busy", busy, 0);
        chk("scoreboard drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
